// File: rtl/rps_match_scorer_pkg.sv
// -----------------------------------------------------------------------------
// rps_pkg -- shared types for the stone-paper-scissors match scorer.
//   res_e   : 2-bit round result codes produced by the upstream round judge
//   win_e   : match winner codes reported on match_winner
//   state_e : match FSM states
// -----------------------------------------------------------------------------
package rps_pkg;

  typedef enum logic [1:0] {
    RES_TIE = 2'b00,
    RES_P1  = 2'b01,
    RES_P2  = 2'b10,
    RES_INV = 2'b11
  } res_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10,
    WIN_DRAW = 2'b11
  } win_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam int CNT_W  = 4;  // tie / invalid / consecutive-tie counter width
  localparam int HIST_W = 8;  // four 2-bit results

endpackage

// File: rtl/rps_match_scorer_if.sv
// -----------------------------------------------------------------------------
// rps_match_scorer_if -- round-result input bundle and score outputs.
//   master : driver side (round judge / board glue); drives ena, result_valid,
//            result, new_match; observes scores and match status.
//   slave  : scorer side; the reverse directions.
// Outputs: p1_score, p2_score (SCORE_W), tie_count, invalid_count (4),
//          match_over, match_done, match_winner (2), history (8).
// -----------------------------------------------------------------------------
interface rps_match_scorer_if #(
  parameter int SCORE_W = 3
);
  logic               ena;
  logic               result_valid;
  logic [1:0]         result;
  logic               new_match;
  logic [SCORE_W-1:0] p1_score;
  logic [SCORE_W-1:0] p2_score;
  logic [3:0]         tie_count;
  logic [3:0]         invalid_count;
  logic               match_over;
  logic               match_done;
  logic [1:0]         match_winner;
  logic [7:0]         history;

  modport master (
    output ena, result_valid, result, new_match,
    input  p1_score, p2_score, tie_count, invalid_count,
           match_over, match_done, match_winner, history
  );

  modport slave (
    input  ena, result_valid, result, new_match,
    output p1_score, p2_score, tie_count, invalid_count,
           match_over, match_done, match_winner, history
  );
endinterface

// File: rtl/rps_match_scorer_sat_counter.sv
// -----------------------------------------------------------------------------
// rps_sat_counter -- W-bit up counter that sticks at all-ones.
//   clk, rst_n : clock, asynchronous active-low reset (count -> 0)
//   ena        : when low the count holds regardless of clr/inc
//   clr        : synchronous clear, takes priority over inc
//   inc        : increment by one unless already saturated
//   count      : current value
// -----------------------------------------------------------------------------
module rps_sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (ena) begin
      if (clr)
        count <= '0;
      else if (inc && (count != '1))
        count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/rps_match_scorer.sv
// -----------------------------------------------------------------------------
// rps_match_scorer -- best-of-N stone-paper-scissors match scorer.
// Consumes one round result per rising edge of result_valid, keeps per-player
// scores plus tie / invalid counts, and declares a winner once a player reaches
// WIN_TARGET decisive wins, or a draw after TIE_LIMIT consecutive ties.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : rps_match_scorer_if.slave (inputs ena, result_valid, result,
//                new_match; outputs scores, counts, match status, history)
// Optional build macro RPS_HISTORY_EN: when defined, history holds the last four
// counted results (newest in [1:0]); otherwise history is tied to zero.
// -----------------------------------------------------------------------------
module rps_match_scorer
  import rps_pkg::*;
#(
  parameter int WIN_TARGET = 3,
  parameter int SCORE_W    = 3,
  parameter int TIE_LIMIT  = 7
) (
  input  logic clk,
  input  logic rst_n,
  rps_match_scorer_if.slave bus
);

  localparam logic [SCORE_W-1:0] WIN_T = SCORE_W'(WIN_TARGET);
  localparam logic [CNT_W-1:0]   TIE_T = CNT_W'(TIE_LIMIT);

  state_e             state_q, state_n;
  logic [SCORE_W-1:0] p1_q, p1_n;
  logic [SCORE_W-1:0] p2_q, p2_n;
  logic [CNT_W-1:0]   streak_q, streak_n;
  win_e               winner_q, winner_n;
  logic               done_q, done_n;
  logic               vld_q;

  logic               round_evt;
  logic               clr;
  logic               tie_inc;
  logic               inv_inc;
  logic               hist_shift;
  logic [CNT_W-1:0]   tie_cnt;
  logic [CNT_W-1:0]   inv_cnt;
  res_e               res;

  assign res       = res_e'(bus.result);
  assign round_evt = bus.result_valid && !vld_q;

  // Next-state / update logic; ena gates every change, so with ena low all
  // update requests stay at their defaults.
  always_comb begin
    state_n    = state_q;
    p1_n       = p1_q;
    p2_n       = p2_q;
    streak_n   = streak_q;
    winner_n   = winner_q;
    done_n     = 1'b0;
    clr        = 1'b0;
    tie_inc    = 1'b0;
    inv_inc    = 1'b0;
    hist_shift = 1'b0;
    if (bus.ena) begin
      if (bus.new_match) begin
        // Start/restart from any state; a coincident round event is dropped.
        state_n  = PLAY;
        p1_n     = '0;
        p2_n     = '0;
        streak_n = '0;
        winner_n = WIN_NONE;
        clr      = 1'b1;
      end else begin
        case (state_q)
          PLAY: begin
            if (round_evt) begin
              hist_shift = 1'b1;
              case (res)
                RES_P1: begin
                  p1_n     = p1_q + 1'b1;
                  streak_n = '0;
                  if (p1_n == WIN_T) begin
                    state_n  = DONE;
                    winner_n = WIN_P1;
                    done_n   = 1'b1;
                  end
                end
                RES_P2: begin
                  p2_n     = p2_q + 1'b1;
                  streak_n = '0;
                  if (p2_n == WIN_T) begin
                    state_n  = DONE;
                    winner_n = WIN_P2;
                    done_n   = 1'b1;
                  end
                end
                RES_TIE: begin
                  tie_inc  = 1'b1;
                  streak_n = streak_q + 1'b1;
                  if (streak_n == TIE_T) begin
                    state_n  = DONE;
                    winner_n = WIN_DRAW;
                    done_n   = 1'b1;
                  end
                end
                default: inv_inc = 1'b1;  // invalid: streak deliberately untouched
              endcase
            end
          end
          IDLE:    state_n = IDLE;
          DONE:    state_n = DONE;
          default: state_n = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      p1_q     <= '0;
      p2_q     <= '0;
      streak_q <= '0;
      winner_q <= WIN_NONE;
      done_q   <= 1'b0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_n;
      p1_q     <= p1_n;
      p2_q     <= p2_n;
      streak_q <= streak_n;
      winner_q <= winner_n;
      done_q   <= done_n;   // always re-evaluated so the pulse lasts one cycle
      if (bus.ena)
        vld_q <= bus.result_valid;
    end
  end

  rps_sat_counter #(.W(CNT_W)) u_tie_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (bus.ena),
    .clr   (clr),
    .inc   (tie_inc),
    .count (tie_cnt)
  );

  rps_sat_counter #(.W(CNT_W)) u_inv_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (bus.ena),
    .clr   (clr),
    .inc   (inv_inc),
    .count (inv_cnt)
  );

`ifdef RPS_HISTORY_EN
  logic [HIST_W-1:0] hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      hist_q <= '0;
    else if (clr)
      hist_q <= '0;
    else if (hist_shift)
      hist_q <= {hist_q[HIST_W-3:0], bus.result};
  end

  assign bus.history = hist_q;
`else
  assign bus.history = '0;
`endif

  assign bus.p1_score      = p1_q;
  assign bus.p2_score      = p2_q;
  assign bus.tie_count     = tie_cnt;
  assign bus.invalid_count = inv_cnt;
  assign bus.match_over    = (state_q == DONE);
  assign bus.match_done    = done_q;
  assign bus.match_winner  = winner_q;

endmodule
